// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the regfile command controller.
package regfile_ctrl_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    // Command opcodes
    localparam logic [1:0] OpWrite = 2'b00;
    localparam logic [1:0] OpRead  = 2'b01;
    localparam logic [1:0] OpMov   = 2'b10;
    localparam logic [1:0] OpSwap  = 2'b11;

    // FSM state encodings
    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StRdA  = 3'd1;
    localparam logic [2:0] StRdB  = 3'd2;
    localparam logic [2:0] StWrA  = 3'd3;
    localparam logic [2:0] StWrB  = 3'd4;
    localparam logic [2:0] StResp = 3'd5;

    typedef struct packed {
        logic [1:0]        op;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs;
        logic [DATA_W-1:0] imm;
    } cmd_t;

    // WRITE is the only command that skips the read phase.
    function automatic logic [2:0] first_state(input logic [1:0] op);
        return (op == OpWrite) ? StWrA : StRdA;
    endfunction

endpackage

// File: rtl/regfile_ctrl_if.sv
// Command, response and regfile-side signals of the controller.
interface regfile_ctrl_if;
    import regfile_ctrl_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_rd;
    logic [ADDR_W-1:0] cmd_rs;
    logic [DATA_W-1:0] cmd_imm;

    logic [ADDR_W-1:0] rf_writenum;
    logic [ADDR_W-1:0] rf_readnum;
    logic              rf_write;
    logic [DATA_W-1:0] rf_data_in;
    logic [DATA_W-1:0] rf_data_out;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    // Front end plus regfile side
    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, rf_data_out,
        input  cmd_ready, rf_writenum, rf_readnum, rf_write, rf_data_in, rsp_valid, rsp_data
    );

    // Controller side
    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, rf_data_out,
        output cmd_ready, rf_writenum, rf_readnum, rf_write, rf_data_in, rsp_valid, rsp_data
    );

endinterface

// File: rtl/regfile_ctrl_dffe.sv
// Load-enable register with asynchronous active-high reset to zero.
module regfile_ctrl_dffe #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    // Hold unless enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Command-driven regfile initiator: sequences reads/writes for WRITE, READ, MOV, SWAP.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    regfile_ctrl_if.slave  bus
);

    logic [2:0]        state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [DATA_W-1:0] tmpa_q, tmpb_q;
    logic              accept;

    logic              cmd_ready;
    logic [ADDR_W-1:0] rf_writenum;
    logic [ADDR_W-1:0] rf_readnum;
    logic              rf_write;
    logic [DATA_W-1:0] rf_data_in;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    // Reset forces IDLE, so ready is additionally masked while reset is held.
    assign cmd_ready = (state_q == StIdle) && !reset;
    assign accept    = cmd_ready && bus.cmd_valid;

    assign cmd_d = '{op: bus.cmd_op, rd: bus.cmd_rd, rs: bus.cmd_rs, imm: bus.cmd_imm};

    regfile_ctrl_dffe #(.Width(3)) u_state (
        .clk   (clk),
        .reset (reset),
        .en_i  (1'b1),
        .d_i   (state_d),
        .q_o   (state_q)
    );

    regfile_ctrl_dffe #(.Width($bits(cmd_t))) u_cmd (
        .clk   (clk),
        .reset (reset),
        .en_i  (accept),
        .d_i   (cmd_d),
        .q_o   (cmd_q)
    );

    regfile_ctrl_dffe #(.Width(DATA_W)) u_tmpa (
        .clk   (clk),
        .reset (reset),
        .en_i  (state_q == StRdA),
        .d_i   (bus.rf_data_out),
        .q_o   (tmpa_q)
    );

    regfile_ctrl_dffe #(.Width(DATA_W)) u_tmpb (
        .clk   (clk),
        .reset (reset),
        .en_i  (state_q == StRdB),
        .d_i   (bus.rf_data_out),
        .q_o   (tmpb_q)
    );

    // Next-state and Moore outputs from state and captured command only
    always_comb begin
        state_d     = state_q;
        rf_writenum = '0;
        rf_readnum  = '0;
        rf_write    = 1'b0;
        rf_data_in  = '0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        case (state_q)
            StIdle: begin
                if (accept) state_d = first_state(bus.cmd_op);
            end
            StRdA: begin
                rf_readnum = cmd_q.rs;
                case (cmd_q.op)
                    OpRead:  state_d = StResp;
                    OpMov:   state_d = StWrA;
                    OpSwap:  state_d = StRdB;
                    default: state_d = StIdle;
                endcase
            end
            StRdB: begin
                rf_readnum = cmd_q.rd;
                state_d    = StWrA;
            end
            StWrA: begin
                rf_write    = 1'b1;
                rf_writenum = cmd_q.rd;
                rf_data_in  = (cmd_q.op == OpWrite) ? cmd_q.imm : tmpa_q;
                state_d     = (cmd_q.op == OpSwap) ? StWrB : StResp;
            end
            StWrB: begin
                rf_write    = 1'b1;
                rf_writenum = cmd_q.rs;
                rf_data_in  = tmpb_q;
                state_d     = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                case (cmd_q.op)
                    OpWrite: rsp_data = cmd_q.imm;
                    OpSwap:  rsp_data = tmpb_q;
                    default: rsp_data = tmpa_q;
                endcase
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.rf_writenum = rf_writenum;
    assign bus.rf_readnum  = rf_readnum;
    assign bus.rf_write    = rf_write;
    assign bus.rf_data_in  = rf_data_in;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_data    = rsp_data;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a behavioural 8x16 regfile.
module tb_regfile_ctrl;
    import regfile_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_ctrl_if bus();

    regfile_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Regfile: synchronous write, combinational read
    logic [DATA_W-1:0] rf_mem [8];
    always_ff @(posedge clk) begin
        if (bus.rf_write) rf_mem[bus.rf_writenum] <= bus.rf_data_in;
    end
    assign bus.rf_data_out = rf_mem[bus.rf_readnum];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Issue one command and check ready, latency, data, write count and pulse width.
    task automatic do_cmd(input string tag, input logic [1:0] op, input int rd, input int rs,
                          input int imm, input int exp_lat, input int exp_data, input int exp_wr);
        int lat;
        int wr;
        int seen;
        logic [DATA_W-1:0] data;
        lat = 0; wr = 0; seen = 0; data = '0;
        @(negedge clk);
        check({tag, "/ready"}, 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rd    = ADDR_W'(rd);
        bus.cmd_rs    = ADDR_W'(rs);
        bus.cmd_imm   = DATA_W'(imm);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_rd    = ADDR_W'($urandom);
        bus.cmd_rs    = ADDR_W'($urandom);
        bus.cmd_imm   = DATA_W'($urandom);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({tag, "/busy"}, 32'(bus.cmd_ready), 0);
            if (bus.rf_write) wr++;
            if (bus.rsp_valid) begin
                seen = 1;
                data = bus.rsp_data;
                break;
            end
        end
        check({tag, "/rsp_seen"}, 32'(seen), 1);
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/rsp_data"}, 32'(data), 32'(exp_data));
        check({tag, "/writes"}, 32'(wr), 32'(exp_wr));
        @(negedge clk);
        check({tag, "/rsp_pulse"}, 32'(bus.rsp_valid), 0);
    endtask

    int first_rsp;
    int ready_at;
    int rsp_cnt;
    int rsp_in_reset;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_rd    = '0;
        bus.cmd_rs    = '0;
        bus.cmd_imm   = '0;
        reset = 1'b1;

        // 1: reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst/rf_write", 32'(bus.rf_write), 0);
        check("rst/rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst/cmd_ready", 32'(bus.cmd_ready), 0);
        check("rst/rf_nums", 32'({bus.rf_writenum, bus.rf_readnum}), 0);
        check("rst/rf_data_in", 32'(bus.rf_data_in), 0);
        check("rst/rsp_data", 32'(bus.rsp_data), 0);
        reset = 1'b0;
        #1;
        check("rst/ready_after", 32'(bus.cmd_ready), 1);

        // 2: write then read back
        do_cmd("wr_r3", OpWrite, 3, 0, 42, 2, 42, 1);
        do_cmd("rd_r3", OpRead, 0, 3, 0, 2, 42, 0);

        // 3: move
        do_cmd("wr_r1", OpWrite, 1, 0, 320, 2, 320, 1);
        do_cmd("mov_r5_r1", OpMov, 5, 1, 0, 3, 320, 1);
        do_cmd("rd_r5", OpRead, 0, 5, 0, 2, 320, 0);
        do_cmd("rd_r1", OpRead, 0, 1, 0, 2, 320, 0);

        // 4: swap, including rd==rs
        do_cmd("wr_r2", OpWrite, 2, 0, 34464, 2, 34464, 1);
        do_cmd("wr_r4", OpWrite, 4, 0, 5, 2, 5, 1);
        do_cmd("swap_r2_r4", OpSwap, 2, 4, 0, 5, 34464, 2);
        do_cmd("rd_r2", OpRead, 0, 2, 0, 2, 5, 0);
        do_cmd("rd_r4", OpRead, 0, 4, 0, 2, 34464, 0);
        do_cmd("swap_r4_r4", OpSwap, 4, 4, 0, 5, 34464, 2);
        do_cmd("rd_r4_same", OpRead, 0, 4, 0, 2, 34464, 0);
        do_cmd("mov_r4_r4", OpMov, 4, 4, 0, 3, 34464, 1);

        // 5: back-to-back with cmd_valid held
        first_rsp = -1; ready_at = -1; rsp_cnt = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OpWrite;
        bus.cmd_rd    = 3'd7;
        bus.cmd_imm   = 16'd0;
        @(posedge clk);
        #1;
        bus.cmd_rd  = 3'd6;
        bus.cmd_imm = 16'd1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                rsp_cnt++;
                if (first_rsp < 0) begin
                    first_rsp = c;
                    check("b2b/rsp0_data", 32'(bus.rsp_data), 0);
                end else begin
                    check("b2b/rsp1_data", 32'(bus.rsp_data), 1);
                end
            end
            if (bus.cmd_ready && ready_at < 0) begin
                ready_at = c;
                @(posedge clk);
                #1;
                bus.cmd_valid = 1'b0;
            end
        end
        check("b2b/first_rsp", 32'(first_rsp), 2);
        check("b2b/ready_after_resp", 32'(ready_at), 3);
        check("b2b/rsp_count", 32'(rsp_cnt), 2);
        do_cmd("rd_r7", OpRead, 0, 7, 0, 2, 0, 0);
        do_cmd("rd_r6", OpRead, 0, 6, 0, 2, 1, 0);

        // 6: reset during WR_B of SWAP rd=1 rs=0
        do_cmd("wr_r0", OpWrite, 0, 0, 3, 2, 3, 1);
        do_cmd("wr_r1b", OpWrite, 1, 0, 320, 2, 320, 1);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OpSwap;
        bus.cmd_rd    = 3'd1;
        bus.cmd_rs    = 3'd0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rstmid/in_wr_b", 32'({bus.rf_write, bus.rf_writenum}), 32'({1'b1, 3'd0}));
        reset = 1'b1;
        #1;
        check("rstmid/rf_write_drop", 32'(bus.rf_write), 0);
        rsp_in_reset = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_in_reset++;
        end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_in_reset++;
        end
        check("rstmid/no_rsp", 32'(rsp_in_reset), 0);
        check("rstmid/ready", 32'(bus.cmd_ready), 1);
        do_cmd("rd_r1_after", OpRead, 0, 1, 0, 2, 3, 0);
        do_cmd("rd_r0_after", OpRead, 0, 0, 0, 2, 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
